bomb_controller: RTL and testbench
==================================

BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 Parameter FUSE_CNT, default 150000000, is the number of clk cycles from bomb placement to detonation.
REQ-002 Parameter EXP_CNT, default 50000000, is the number of clk cycles the explosion stays visible.
REQ-003 Parameter ANIM_CNT, default 12500000, is the number of clk cycles per fuse animation frame.
REQ-004 clk  input  1  system clock; the block uses this one clock only.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 place  input  1  bomb button, level-sensitive.
REQ-007 chain  input  1  bomb is hit by another explosion; forces early detonation.
REQ-008 gameover  input  1  asserted when game lives reach 0.
REQ-009 x_b, y_b  input  10 each  bomberman sprite top-left corner in arena coordinates.
REQ-010 blk_ack  input  1  block-map handshake acknowledge.
REQ-011 bomb_active  output  1  bomb is on the map and the fuse is burning.
REQ-012 exp_active  output  1  explosion is displayed and lethal.
REQ-013 bomb_x, bomb_y  output  10 each  tile-aligned top-left corner of the bomb.
REQ-014 bomb_frame  output  2  fuse animation frame index.
REQ-015 blk_req  output  1  request to clear the neighbouring tile.
REQ-016 blk_dir  output  2  direction of that tile: 00 U, 01 R, 10 D, 11 L.
REQ-017 busy  output  1  asserted in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ARMED, CLEAR, EXPLODE.
REQ-019 The block SHALL register place and detect its rising edge; only that edge SHALL start a placement.
REQ-020 In IDLE, a place edge with gameover=0 SHALL latch the bomb position and enter ARMED on the next clk. A place edge while busy or gameover=1 SHALL be ignored.
REQ-021 Bomb position SHALL be latched as follows:
- bomb_x = 48 + (((x_b + 8 - 48) >> 4) << 4)
- bomb_y = 32 + (((y_b + 16 - 32) >> 4) << 4)
- all arithmetic is 10-bit, taken from the hitbox centre.
REQ-022 In ARMED, a fuse counter SHALL count from 0. The FSM SHALL enter CLEAR when the count reaches FUSE_CNT-1, or on the cycle after chain=1, whichever is first.
REQ-023 In ARMED, bomb_frame SHALL step through 0,1,2,1,0,... advancing every ANIM_CNT cycles. It SHALL be 0 on entry to ARMED and 0 in all other states.
REQ-024 In CLEAR, the block SHALL issue four handshakes in the order U, R, D, L:
- blk_req is held high with blk_dir stable until a cycle with blk_ack=1;
- blk_req drops for at least one cycle between requests;
- after the L acknowledge, the FSM enters EXPLODE.
REQ-025 blk_ack received while blk_req=0 SHALL be ignored.
REQ-026 In EXPLODE, exp_active SHALL be 1 for exactly EXP_CNT cycles, after which the FSM SHALL return to IDLE.
REQ-027 bomb_active SHALL be 1 only in ARMED. bomb_x/bomb_y SHALL hold their value through EXPLODE and until the next placement.
REQ-028 gameover=1 in ARMED SHALL freeze the fuse and animation counters.
REQ-029 gameover=1 in CLEAR or EXPLODE SHALL not stop the sequence.
REQ-030 A place edge and chain in the same cycle while in IDLE SHALL start the placement; chain SHALL be ignored in IDLE.

Reset
REQ-031 When reset=0 at a clk edge, the FSM SHALL enter IDLE and all counters SHALL clear.
REQ-032 During reset:
- bomb_active, exp_active, blk_req and busy are 0;
- bomb_frame is 0 and blk_dir is 00;
- bomb_x is 48 and bomb_y is 32.
REQ-033 Reset mid-handshake SHALL drop blk_req in the same edge. No pending place edge SHALL survive reset.

Structure
REQ-034 The FSM state enum, direction codes (shared with the cd encoding of bomberman), arena origin 48/32 and tile size 16 SHALL live in the shared game package.
REQ-035 The block SHALL contain one sub-module, bomb_timer: a loadable down-counter with a done pulse and a freeze input, used for both the fuse and the explosion.

Verification (FUSE_CNT=20, EXP_CNT=10, ANIM_CNT=4)
REQ-036 Placement position: reset, then x_b=70, y_b=40, place pulse -> one cycle later bomb_active=1, bomb_x=64, bomb_y=48.
REQ-037 Fuse and animation: place with blk_ack tied high -> bomb_frame sequence 0,1,2,1,0 every 4 cycles; blk_req first rises 20 cycles after ARMED entry; exp_active high for 10 cycles; busy falls after that.
REQ-038 Handshake: blk_ack delayed 3 cycles per request -> blk_dir 00,01,10,11 in order, each held stable, with a blk_req low gap between requests.
REQ-039 Early detonation: chain=1 at fuse count 5 -> CLEAR entered on the next cycle; a second place edge during ARMED is ignored and bomb_x is unchanged.
REQ-040 Gameover and reset: gameover=1 for 7 cycles in ARMED -> detonation delayed by 7 cycles; reset=0 during CLEAR -> all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/bomb_controller_pkg.sv
// Shared game types: controller states, tile directions (same code as bomberman cd),
// arena origin and tile geometry used to snap sprite positions onto the bomb grid.
package bomb_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_EXPLODE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_U = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_L = 2'b11
  } dir_e;

  localparam logic [9:0] ARENA_X0   = 10'd48;
  localparam logic [9:0] ARENA_Y0   = 10'd32;
  localparam int         TILE_SIZE  = 16;
  localparam int         TILE_SHIFT = $clog2(TILE_SIZE);

  // Offsets from sprite top-left to hitbox centre.
  localparam logic [9:0] HIT_CX = 10'd8;
  localparam logic [9:0] HIT_CY = 10'd16;

  // All terms are 10 bit, so positions left of the origin wrap like the original.
  function automatic logic [9:0] tile_align(input logic [9:0] pos,
                                            input logic [9:0] ctr,
                                            input logic [9:0] org);
    logic [9:0] rel;
    rel = pos + ctr - org;
    return org + ((rel >> TILE_SHIFT) << TILE_SHIFT);
  endfunction

  function automatic logic [1:0] anim_frame(input logic [1:0] phase);
    return (phase == 2'd3) ? 2'd1 : phase;
  endfunction

endpackage

// File: rtl/bomb_controller_if.sv
// Game-side signals of the bomb controller; slave is the controller, master the game logic.
interface bomb_controller_if;
  import bomb_controller_pkg::*;

  logic       place;
  logic       chain;
  logic       gameover;
  logic [9:0] x_b;
  logic [9:0] y_b;
  logic       blk_ack;

  logic       bomb_active;
  logic       exp_active;
  logic [9:0] bomb_x;
  logic [9:0] bomb_y;
  logic [1:0] bomb_frame;
  logic       blk_req;
  dir_e       blk_dir;
  logic       busy;

  modport master (
    output place, chain, gameover, x_b, y_b, blk_ack,
    input  bomb_active, exp_active, bomb_x, bomb_y, bomb_frame, blk_req, blk_dir, busy
  );

  modport slave (
    input  place, chain, gameover, x_b, y_b, blk_ack,
    output bomb_active, exp_active, bomb_x, bomb_y, bomb_frame, blk_req, blk_dir, busy
  );

endinterface

// File: rtl/bomb_controller_timer.sv
// Loadable down-counter shared by the fuse and the explosion; done pulses while running at zero.
// Load wins over counting; freeze holds the value and suppresses done.
module bomb_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         run_i,
  input  logic         freeze_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         step;

  assign step = run_i & ~freeze_i;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (step && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = step & (cnt_q == '0);

endmodule

// File: rtl/bomb_controller.sv
// Bomb lifecycle: place -> fuse (ARMED) -> clear four neighbour tiles (CLEAR) -> explosion.
// Placement takes effect one clk after the place edge; block-map clears wait on blk_ack.
module bomb_controller
  import bomb_controller_pkg::*;
#(
  parameter int FUSE_CNT = 150000000,
  parameter int EXP_CNT  = 50000000,
  parameter int ANIM_CNT = 12500000
) (
  input logic               clk,
  input logic               reset,
  bomb_controller_if.slave  bus
);

  localparam int TMAX = (FUSE_CNT > EXP_CNT) ? FUSE_CNT : EXP_CNT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(ANIM_CNT + 1);

  localparam logic [TW-1:0] FUSE_LD   = TW'(FUSE_CNT - 1);
  localparam logic [TW-1:0] EXP_LD    = TW'(EXP_CNT - 1);
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_CNT - 1);

  state_e        state_q, state_d;
  logic          place_q;
  logic [9:0]    bomb_x_q, bomb_x_d;
  logic [9:0]    bomb_y_q, bomb_y_d;
  dir_e          dir_q, dir_d;
  logic          gap_q, gap_d;
  logic [AW-1:0] anim_q, anim_d;
  logic [1:0]    phase_q, phase_d;

  logic          place_edge;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_run;
  logic          tmr_freeze;
  logic          tmr_done;

  assign place_edge = bus.place & ~place_q;
  assign tmr_freeze = bus.gameover & (state_q == ST_ARMED);

  bomb_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .run_i      (tmr_run),
    .freeze_i   (tmr_freeze),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    bomb_x_d = bomb_x_q;
    bomb_y_d = bomb_y_q;
    dir_d    = dir_q;
    gap_d    = gap_q;
    anim_d   = anim_q;
    phase_d  = phase_q;
    tmr_load = 1'b0;
    tmr_val  = FUSE_LD;
    tmr_run  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (place_edge && !bus.gameover) begin
          state_d  = ST_ARMED;
          bomb_x_d = tile_align(bus.x_b, HIT_CX, ARENA_X0);
          bomb_y_d = tile_align(bus.y_b, HIT_CY, ARENA_Y0);
          tmr_load = 1'b1;
          tmr_val  = FUSE_LD;
          anim_d   = '0;
          phase_d  = 2'd0;
        end
      end

      ST_ARMED: begin
        tmr_run = 1'b1;
        if (bus.chain || tmr_done) begin
          state_d = ST_CLEAR;
          dir_d   = DIR_U;
          gap_d   = 1'b0;
        end else if (!bus.gameover) begin
          if (anim_q == ANIM_LAST) begin
            anim_d  = '0;
            phase_d = phase_q + 2'd1;
          end else begin
            anim_d = anim_q + AW'(1);
          end
        end
      end

      ST_CLEAR: begin
        // One idle cycle after every acknowledge separates consecutive requests.
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (bus.blk_ack) begin
          if (dir_q == DIR_L) begin
            state_d  = ST_EXPLODE;
            tmr_load = 1'b1;
            tmr_val  = EXP_LD;
          end else begin
            dir_d = dir_e'(dir_q + 2'd1);
            gap_d = 1'b1;
          end
        end
      end

      ST_EXPLODE: begin
        tmr_run = 1'b1;
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      // Sampling the button here means a press held across reset is not an edge.
      place_q  <= bus.place;
      bomb_x_q <= ARENA_X0;
      bomb_y_q <= ARENA_Y0;
      dir_q    <= DIR_U;
      gap_q    <= 1'b0;
      anim_q   <= '0;
      phase_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      place_q  <= bus.place;
      bomb_x_q <= bomb_x_d;
      bomb_y_q <= bomb_y_d;
      dir_q    <= dir_d;
      gap_q    <= gap_d;
      anim_q   <= anim_d;
      phase_q  <= phase_d;
    end
  end

  assign bus.bomb_active = (state_q == ST_ARMED);
  assign bus.exp_active  = (state_q == ST_EXPLODE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.bomb_x      = bomb_x_q;
  assign bus.bomb_y      = bomb_y_q;
  assign bus.bomb_frame  = (state_q == ST_ARMED) ? anim_frame(phase_q) : 2'd0;
  assign bus.blk_req     = (state_q == ST_CLEAR) & ~gap_q;
  assign bus.blk_dir     = (state_q == ST_CLEAR) ? dir_q : DIR_U;

endmodule

// File: tb/tb_bomb_controller.sv
// Directed scenarios plus random stimulus, every cycle compared against a behavioural model.
module tb_bomb_controller;

  localparam int FUSE = 20;
  localparam int EXP  = 10;
  localparam int ANIM = 4;

  localparam int M_IDLE  = 0;
  localparam int M_FUSE  = 1;
  localparam int M_CLEAR = 2;
  localparam int M_BOOM  = 3;

  logic clk = 1'b0;
  logic reset;
  logic place_r, chain_r, go_r, ack_r;
  logic [9:0] xb_r, yb_r;

  bomb_controller_if bus ();

  assign bus.place    = place_r;
  assign bus.chain    = chain_r;
  assign bus.gameover = go_r;
  assign bus.blk_ack  = ack_r;
  assign bus.x_b      = xb_r;
  assign bus.y_b      = yb_r;

  bomb_controller #(
    .FUSE_CNT (FUSE),
    .EXP_CNT  (EXP),
    .ANIM_CNT (ANIM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: elapsed fuse time, handshake index and explosion age.
  int         m_mode, m_age, m_hs, m_exp;
  bit         m_gap, m_prev;
  logic [9:0] m_bx, m_by;
  int         frame_tbl [4] = '{0, 1, 2, 1};

  function automatic logic [9:0] snap(input int p, input int ctr, input int org);
    int rel;
    rel = (p + ctr - org) & 1023;
    return 10'((org + (rel / 16) * 16) & 1023);
  endfunction

  task model_edge();
    bit pe;
    if (!reset) begin
      m_mode = M_IDLE;
      m_prev = place_r;
      m_bx = 10'd48;
      m_by = 10'd32;
      m_age = 0;
      m_hs = 0;
      m_gap = 0;
      m_exp = 0;
    end else begin
      pe = place_r && !m_prev;
      m_prev = place_r;
      case (m_mode)
        M_IDLE: if (pe && !go_r) begin
          m_bx = snap(int'(xb_r), 8, 48);
          m_by = snap(int'(yb_r), 16, 32);
          m_age = 0;
          m_mode = M_FUSE;
        end
        M_FUSE: begin
          if (chain_r || (!go_r && m_age == FUSE - 1)) begin
            m_mode = M_CLEAR;
            m_hs = 0;
            m_gap = 0;
          end else if (!go_r) begin
            m_age++;
          end
        end
        M_CLEAR: begin
          if (m_gap) m_gap = 0;
          else if (ack_r) begin
            if (m_hs == 3) begin
              m_mode = M_BOOM;
              m_exp = 0;
            end else begin
              m_hs++;
              m_gap = 1;
            end
          end
        end
        default: begin
          if (m_exp == EXP - 1) m_mode = M_IDLE;
          else m_exp++;
        end
      endcase
    end
  endtask

  task check_outputs();
    bit req;
    req = (m_mode == M_CLEAR) && !m_gap;
    check("bomb_active", 32'(bus.bomb_active), 32'(m_mode == M_FUSE));
    check("exp_active", 32'(bus.exp_active), 32'(m_mode == M_BOOM));
    check("busy", 32'(bus.busy), 32'(m_mode != M_IDLE));
    check("bomb_x", 32'(bus.bomb_x), 32'(m_bx));
    check("bomb_y", 32'(bus.bomb_y), 32'(m_by));
    check("bomb_frame", 32'(bus.bomb_frame),
          (m_mode == M_FUSE) ? 32'(frame_tbl[(m_age / ANIM) % 4]) : 32'd0);
    check("blk_req", 32'(bus.blk_req), 32'(req));
    if (req) check("blk_dir", 32'(bus.blk_dir), 32'(m_hs));
  endtask

  task step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task drain(input string tag);
    ack_r = 1'b1;
    for (int i = 0; i < 200 && bus.busy; i++) step();
    check(tag, 32'(bus.busy), 32'd0);
    ack_r = 1'b0;
  endtask

  initial begin
    int lat, n, req_run;
    logic [1:0] dirs [$];

    reset = 1'b0; place_r = 1'b0; chain_r = 1'b0; go_r = 1'b0; ack_r = 1'b0;
    xb_r = '0; yb_r = '0;
    repeat (2) step();
    check("rst_bomb_x", 32'(bus.bomb_x), 32'd48);
    check("rst_bomb_y", 32'(bus.bomb_y), 32'd32);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    step();

    // Placement position
    xb_r = 10'd70; yb_r = 10'd40; place_r = 1'b1;
    step();
    place_r = 1'b0;
    check("place_active", 32'(bus.bomb_active), 32'd1);
    check("place_x", 32'(bus.bomb_x), 32'd64);
    check("place_y", 32'(bus.bomb_y), 32'd48);

    // Fuse length and explosion length with blk_ack tied high
    ack_r = 1'b1;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.blk_req) begin lat = i; break; end
    end
    check("fuse_latency", 32'(lat), 32'd20);
    n = 0;
    for (int i = 0; i < 200 && bus.busy; i++) begin
      step();
      if (bus.exp_active) n++;
    end
    check("exp_len", 32'(n), 32'd10);
    check("idle_after_exp", 32'(bus.busy), 32'd0);

    // Handshake with acknowledge delayed three cycles
    ack_r = 1'b0; place_r = 1'b1;
    step();
    place_r = 1'b0;
    req_run = 0;
    for (int i = 0; i < 300 && bus.busy; i++) begin
      ack_r = (req_run >= 3);
      step();
      if (bus.blk_req) begin
        req_run++;
        if (req_run == 1) dirs.push_back(bus.blk_dir);
      end else begin
        req_run = 0;
      end
    end
    check("hs_count", 32'(dirs.size()), 32'd4);
    for (int i = 0; i < dirs.size(); i++) check("hs_dir", 32'(dirs[i]), 32'(i));
    ack_r = 1'b0;

    // Early detonation by chain; second place edge while armed is ignored
    xb_r = 10'd200; yb_r = 10'd100; place_r = 1'b1;
    step();
    place_r = 1'b0;
    step();
    xb_r = 10'd300; place_r = 1'b1;
    step();
    place_r = 1'b0;
    repeat (3) step();
    chain_r = 1'b1;
    step();
    chain_r = 1'b0;
    check("chain_clear", 32'(bus.blk_req), 32'd1);
    check("chain_keep_x", 32'(bus.bomb_x), 32'(snap(200, 8, 48)));
    drain("chain_drain");

    // Gameover freezes the fuse for seven cycles
    place_r = 1'b1;
    step();
    place_r = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      go_r = (i >= 3 && i < 10);
      step();
      if (bus.blk_req) begin lat = i; break; end
    end
    go_r = 1'b0;
    check("frozen_latency", 32'(lat), 32'd27);

    // Reset in the middle of CLEAR
    step();
    reset = 1'b0;
    step();
    check("rst_clear_req", 32'(bus.blk_req), 32'd0);
    check("rst_clear_busy", 32'(bus.busy), 32'd0);
    check("rst_clear_x", 32'(bus.bomb_x), 32'd48);
    check("rst_clear_dir", 32'(bus.blk_dir), 32'd0);
    reset = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) place_r = ~place_r;
      chain_r = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 29) == 0) go_r = ~go_r;
      ack_r   = $urandom_range(0, 1) != 0;
      xb_r    = 10'($urandom);
      yb_r    = 10'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
